data_mem_unit: RTL and testbench

- Data-memory stage directly downstream of the control unit. It consumes load/store requests: address, store data, access size and read/write strobes.
- Holds a word-organised, little-endian data RAM and performs byte, half and word accesses with byte-lane steering.
- Returns sign- or zero-extended load data with a one-cycle valid pulse, and flags misaligned or out-of-range accesses.
- busy/valid handshake lets the control FSM stall until data or write completion is reported.

---
 rtl/data_mem_unit.sv | 178 +++++++++++++++++
 tb/tb_data_mem_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_unit.sv
// data_mem_unit: word-organised little-endian data RAM behind a busy/valid handshake.
// Byte/half/word loads and stores with lane steering, load extension and request rejection.
`default_nettype none

module data_mem_unit #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    output logic        busy,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        wdone,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RD_WAIT   = 2'd1,
        RD_RESP   = 2'd2,
        WR_COMMIT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [1:0]      lane_q, lane_d;
    logic [1:0]      size_q, size_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            uns_q, uns_d;
    logic [31:0]     word_q, word_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            rvalid_q, rvalid_d;
    logic            wdone_q, wdone_d;
    logic            err_q, err_d;

    logic [31:0]     mem [DEPTH_WORDS];

    logic [32:0]     diff;
    logic            reject;
    logic [31:0]     rd_shift;
    logic [31:0]     rd_ext;
    logic [31:0]     wr_shift;
    logic [3:0]      wr_be;

    // The borrow bit of the 33-bit subtraction flags addresses below ADDR_BASE.
    always_comb begin
        diff   = {1'b0, addr} - {1'b0, ADDR_BASE};
        reject = (req_rd && req_wr)
              || (size == 2'b11)
              || (size == 2'b01 && addr[0])
              || (size == 2'b10 && addr[1:0] != 2'b00)
              || diff[32]
              || (diff[31:2] >= 30'(DEPTH_WORDS));
    end

    always_comb begin
        rd_shift = word_q >> {lane_q, 3'b000};
        case (size_q)
            2'b00:   rd_ext = uns_q ? {24'd0, rd_shift[7:0]}
                                    : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   rd_ext = uns_q ? {16'd0, rd_shift[15:0]}
                                    : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    always_comb begin
        wr_shift = wdata_q << {lane_q, 3'b000};
        case (size_q)
            2'b00:   wr_be = 4'b0001 << lane_q;
            2'b01:   wr_be = 4'b0011 << lane_q;
            default: wr_be = 4'b1111;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        lane_d   = lane_q;
        size_d   = size_q;
        wdata_d  = wdata_q;
        uns_d    = uns_q;
        word_d   = word_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        wdone_d  = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_rd || req_wr) begin
                    idx_d   = diff[AW+1:2];
                    lane_d  = diff[1:0];
                    size_d  = size;
                    wdata_d = wdata;
                    uns_d   = unsigned_ld;
                    if (reject) begin
                        err_d = 1'b1;
                    end else if (req_rd) begin
                        state_d = RD_WAIT;
                    end else begin
                        state_d = WR_COMMIT;
                    end
                end
            end
            RD_WAIT: begin
                word_d  = mem[idx_q];
                state_d = RD_RESP;
            end
            RD_RESP: begin
                rdata_d  = rd_ext;
                rvalid_d = 1'b1;
                state_d  = IDLE;
            end
            WR_COMMIT: begin
                wdone_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            lane_q   <= 2'b00;
            size_q   <= 2'b00;
            wdata_q  <= 32'd0;
            uns_q    <= 1'b0;
            word_q   <= 32'd0;
            rdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
            wdone_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            lane_q   <= lane_d;
            size_q   <= size_d;
            wdata_q  <= wdata_d;
            uns_q    <= uns_d;
            word_q   <= word_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            wdone_q  <= wdone_d;
            err_q    <= err_d;
        end
    end

    // RAM is not reset; an async reset forces IDLE so a pending commit is dropped.
    always_ff @(posedge clk) begin
        if (state_q == WR_COMMIT) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[idx_q][8*i +: 8] <= wr_shift[8*i +: 8];
                end
            end
        end
    end

    assign busy   = (state_q != IDLE);
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign wdone  = wdone_q;
    assign err    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit: directed plus randomized checks of data_mem_unit against a byte-array model.
`default_nettype none

module tb_data_mem_unit;

    localparam int DEPTH = 64;
    localparam int NBYTES = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_rd = 1'b0;
    logic        req_wr = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [1:0]  size = 2'b00;
    logic        unsigned_ld = 1'b0;
    logic        busy;
    logic [31:0] rdata;
    logic        rvalid;
    logic        wdone;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mm [NBYTES];
    logic [31:0] exp_rdata = 32'd0;

    data_mem_unit #(
        .DEPTH_WORDS (DEPTH),
        .ADDR_BASE   (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_rd      (req_rd),
        .req_wr      (req_wr),
        .addr        (addr),
        .wdata       (wdata),
        .size        (size),
        .unsigned_ld (unsigned_ld),
        .busy        (busy),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .wdone       (wdone),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_err(input logic rd, input logic wr, input logic [31:0] a,
                                     input logic [1:0] sz);
        return (rd && wr) || (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0)
            || (sz == 2'd2 && (a % 4) != 0) || (a >= 32'(NBYTES));
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                               input logic un);
        logic [31:0] v;
        int b;
        b = int'(a);
        if (sz == 2'd0) begin
            v = {24'd0, mm[b]};
            if (!un && mm[b][7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = {16'd0, mm[b+1], mm[b]};
            if (!un && mm[b+1][7]) v = v | 32'hFFFF_0000;
        end else begin
            v = {mm[b+3], mm[b+2], mm[b+1], mm[b]};
        end
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
        int n;
        n = 1 << sz;
        for (int i = 0; i < n; i++) mm[int'(a) + i] = wd[8*i +: 8];
    endtask

    // Issues one request at the next edge and follows it to completion; on return the
    // bench sits in the pulse cycle, so the next call is a back-to-back request.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] sz, input logic un,
                          input bit disturb);
        bit e;
        e = model_err(rd, wr, a, sz);
        req_rd = rd; req_wr = wr; addr = a; wdata = wd; size = sz; unsigned_ld = un;
        tick();
        req_rd = 1'b0; req_wr = 1'b0;
        if (!rd && !wr) begin
            chk("idle_busy", {31'd0, busy}, 32'd0);
            chk("idle_pulses", {29'd0, err, rvalid, wdone}, 32'd0);
        end else if (e) begin
            chk("err_pulse", {31'd0, err}, 32'd1);
            chk("err_busy", {31'd0, busy}, 32'd0);
            chk("err_others", {30'd0, rvalid, wdone}, 32'd0);
            chk("err_rdata", rdata, exp_rdata);
        end else begin
            chk("acc_busy", {31'd0, busy}, 32'd1);
            chk("acc_pulses", {29'd0, err, rvalid, wdone}, 32'd0);
            if (disturb) begin
                req_wr = 1'b1; addr = a ^ 32'h40; wdata = ~wd; size = 2'd2;
            end
            if (wr) begin
                tick();
                req_wr = 1'b0;
                model_store(a, wd, sz);
                chk("wdone", {31'd0, wdone}, 32'd1);
                chk("wr_busy", {31'd0, busy}, 32'd0);
                chk("wr_others", {30'd0, err, rvalid}, 32'd0);
            end else begin
                tick();
                chk("rd_wait_busy", {31'd0, busy}, 32'd1);
                chk("rd_wait_rvalid", {31'd0, rvalid}, 32'd0);
                tick();
                req_wr = 1'b0;
                exp_rdata = model_load(a, sz, un);
                chk("rvalid", {31'd0, rvalid}, 32'd1);
                chk("rdata", rdata, exp_rdata);
                chk("rd_busy", {31'd0, busy}, 32'd0);
                chk("rd_others", {30'd0, err, wdone}, 32'd0);
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        logic        rd, wr;
        int          r;

        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pulses", {29'd0, err, rvalid, wdone}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst = 1'b0;

        for (int w = 0; w < DEPTH; w++)
            do_req(1'b0, 1'b1, 32'(4 * w), $urandom, 2'd2, 1'b0, 1'b0);

        // Word, byte-lane and half-extension sequence.
        do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 1'b0);
        do_req(1'b1, 1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 1'b0);
        chk("tp_lw", rdata, 32'hDEADBEEF);
        do_req(1'b0, 1'b1, 32'h13, 32'h55, 2'd0, 1'b0, 1'b1);
        do_req(1'b1, 1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 1'b0);
        chk("tp_word_after_sb", rdata, 32'h55ADBEEF);
        do_req(1'b1, 1'b0, 32'h12, 32'd0, 2'd0, 1'b0, 1'b0);
        chk("tp_lb", rdata, 32'hFFFFFFAD);
        do_req(1'b1, 1'b0, 32'h12, 32'd0, 2'd0, 1'b1, 1'b0);
        chk("tp_lbu", rdata, 32'h000000AD);
        do_req(1'b1, 1'b0, 32'h12, 32'd0, 2'd1, 1'b0, 1'b1);
        chk("tp_lh", rdata, 32'h000055AD);
        do_req(1'b0, 1'b1, 32'h20, 32'h8001, 2'd1, 1'b0, 1'b0);
        do_req(1'b1, 1'b0, 32'h20, 32'd0, 2'd1, 1'b0, 1'b0);
        chk("tp_lh_neg", rdata, 32'hFFFF8001);
        do_req(1'b1, 1'b0, 32'h20, 32'd0, 2'd1, 1'b1, 1'b0);
        chk("tp_lhu", rdata, 32'h00008001);

        // Rejected requests.
        do_req(1'b1, 1'b0, 32'h22, 32'd0, 2'd2, 1'b0, 1'b0);
        do_req(1'b0, 1'b1, 32'h21, 32'hFFFF, 2'd1, 1'b0, 1'b0);
        do_req(1'b1, 1'b0, 32'h10, 32'd0, 2'd3, 1'b0, 1'b0);
        do_req(1'b1, 1'b1, 32'h10, 32'h0, 2'd2, 1'b0, 1'b0);
        do_req(1'b0, 1'b1, 32'(NBYTES), 32'h1, 2'd2, 1'b0, 1'b0);
        do_req(1'b1, 1'b0, 32'hFFFF_FFFC, 32'd0, 2'd2, 1'b0, 1'b0);
        do_req(1'b1, 1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 1'b0);
        chk("err_ram_kept", rdata, 32'h55ADBEEF);

        // Async reset while a store is pending commit.
        do_req(1'b1, 1'b0, 32'h30, 32'd0, 2'd2, 1'b0, 1'b0);
        req_wr = 1'b1; addr = 32'h30; wdata = 32'h12345678; size = 2'd2;
        tick();
        req_wr = 1'b0;
        chk("ar_busy_before", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_outs", {29'd0, err, rvalid, wdone}, 32'd0);
        chk("ar_rdata", rdata, 32'd0);
        exp_rdata = 32'd0;
        rst = 1'b0;
        tick();
        chk("ar_no_wdone", {31'd0, wdone}, 32'd0);
        do_req(1'b1, 1'b0, 32'h30, 32'd0, 2'd2, 1'b0, 1'b0);

        // Async reset during a load.
        req_rd = 1'b1; addr = 32'h10; size = 2'd2;
        tick();
        req_rd = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("ar_rd_rdata", rdata, 32'd0);
        chk("ar_rd_busy", {31'd0, busy}, 32'd0);
        exp_rdata = 32'd0;
        rst = 1'b0;
        tick();
        chk("ar_rd_no_rvalid", {31'd0, rvalid}, 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            r  = int'($urandom_range(0, 9));
            rd = (r < 5) || (r == 9);
            wr = (r >= 5);
            if (r == 8) begin rd = 1'b0; wr = 1'b0; end
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, NBYTES + 15));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            if ($urandom_range(0, 40) == 0) a = 32'hFFFF_FFF0;
            do_req(rd, wr, a, $urandom, sz, 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
